// File: rtl/note_scroller.sv
// Scrolling note field: live notes step one pixel left per frame, each step erasing and
// redrawing every note through a req/done handshake with a downstream square drawer.
module note_scroller #(
  parameter int unsigned NUM_NOTES = 8,
  parameter int unsigned FRAME_DIV = 833333,
  parameter logic [7:0]  X_START   = 8'd156,
  parameter logic [7:0]  X_END     = 8'd0,
  parameter logic [7:0]  HIT_LO    = 8'd8,
  parameter logic [7:0]  HIT_HI    = 8'd15,
  parameter logic [2:0]  BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       spawn,
  input  logic [2:0] spawn_colour,
  input  logic       draw_done,
  output logic       draw_req,
  output logic [7:0] draw_x,
  output logic [2:0] draw_colour,
  output logic       hit_window,
  output logic       miss,
  output logic       overflow,
  output logic       busy
);

  localparam int unsigned IdxW = $clog2(NUM_NOTES + 1);
  localparam int unsigned SelW = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1;
  localparam int unsigned CntW = $clog2(FRAME_DIV + 1);
  localparam logic [IdxW-1:0] NumIdx  = IdxW'(NUM_NOTES);
  localparam logic [CntW-1:0] CntLast = CntW'(FRAME_DIV - 1);

  typedef enum logic [2:0] {
    StIdle, StErase, StEraseWait, StMove, StDraw, StDrawWait, StNext
  } state_e;

  state_e               state_q;
  logic [NUM_NOTES-1:0] valid_q;
  logic [7:0]           x_q      [NUM_NOTES];
  logic [2:0]           colour_q [NUM_NOTES];
  logic [IdxW-1:0]      idx_q;
  logic [CntW-1:0]      cnt_q;
  logic                 pend_q;
  logic [2:0]           pend_colour_q;

  logic [SelW-1:0] sel;
  logic [SelW-1:0] free_idx;
  logic            free_found;
  logic            hit_any;
  logic            place_en;
  logic [2:0]      place_colour;
  logic [7:0]      new_x;

  assign sel   = idx_q[SelW-1:0];
  assign new_x = x_q[sel] - 8'd1;
  assign busy  = (state_q != StIdle);

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    hit_any    = 1'b0;
    for (int unsigned i = 0; i < NUM_NOTES; i++) begin
      if (!valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = SelW'(i);
      end
      if (valid_q[i] && (x_q[i] >= HIT_LO) && (x_q[i] <= HIT_HI)) hit_any = 1'b1;
    end
  end

  // A pending spawn takes precedence on IDLE entry; a fresh spawn that cycle becomes pending.
  always_comb begin
    place_en     = 1'b0;
    place_colour = spawn_colour;
    if (state_q == StIdle) begin
      if (pend_q) begin
        place_en     = 1'b1;
        place_colour = pend_colour_q;
      end else if (spawn) begin
        place_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      valid_q       <= '0;
      idx_q         <= '0;
      cnt_q         <= '0;
      pend_q        <= 1'b0;
      pend_colour_q <= '0;
      for (int unsigned i = 0; i < NUM_NOTES; i++) begin
        x_q[i]      <= '0;
        colour_q[i] <= '0;
      end
      draw_req    <= 1'b0;
      draw_x      <= '0;
      draw_colour <= BG_COLOUR;
      hit_window  <= 1'b0;
      miss        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      miss       <= 1'b0;
      overflow   <= 1'b0;
      hit_window <= hit_any;

      if (place_en) begin
        if (free_found) begin
          valid_q[free_idx]  <= 1'b1;
          x_q[free_idx]      <= X_START;
          colour_q[free_idx] <= place_colour;
        end else begin
          overflow <= 1'b1;
        end
      end

      if (state_q == StIdle) begin
        if (pend_q) begin
          pend_q        <= spawn;
          pend_colour_q <= spawn_colour;
        end
      end else if (spawn) begin
        if (pend_q) begin
          overflow <= 1'b1;
        end else begin
          pend_q        <= 1'b1;
          pend_colour_q <= spawn_colour;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (enable) begin
            if (cnt_q == CntLast) begin
              cnt_q   <= '0;
              idx_q   <= '0;
              state_q <= StNext;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StNext: begin
          if (idx_q == NumIdx)    state_q <= StIdle;
          else if (valid_q[sel])  state_q <= StErase;
          else                    idx_q   <= idx_q + 1'b1;
        end
        StErase: begin
          draw_req    <= 1'b1;
          draw_x      <= x_q[sel];
          draw_colour <= BG_COLOUR;
          state_q     <= StEraseWait;
        end
        StEraseWait: begin
          if (draw_req && draw_done) begin
            draw_req <= 1'b0;
            state_q  <= StMove;
          end
        end
        StMove: begin
          x_q[sel] <= new_x;
          if (new_x == X_END) begin
            valid_q[sel] <= 1'b0;
            miss         <= 1'b1;
            idx_q        <= idx_q + 1'b1;
            state_q      <= StNext;
          end else begin
            state_q <= StDraw;
          end
        end
        StDraw: begin
          draw_req    <= 1'b1;
          draw_x      <= x_q[sel];
          draw_colour <= colour_q[sel];
          state_q     <= StDrawWait;
        end
        StDrawWait: begin
          if (draw_req && draw_done) begin
            draw_req <= 1'b0;
            idx_q    <= idx_q + 1'b1;
            state_q  <= StNext;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_note_scroller.sv
// Bench for note_scroller: random spawns and drawer latencies checked against a slot-list model
// that predicts the erase/draw/miss sequence of every scroll step.
module tb_note_scroller;

  localparam int unsigned NumNotes = 8;
  localparam int unsigned FrameDiv = 4;
  localparam int          XStart   = 156;
  localparam int          XEnd     = 0;
  localparam int          HitLo    = 8;
  localparam int          HitHi    = 15;
  localparam logic [2:0]  Bg       = 3'b000;

  typedef logic [13:0] ev_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       spawn;
  logic [2:0] spawn_colour;
  logic       draw_done;
  logic       draw_req;
  logic [7:0] draw_x;
  logic [2:0] draw_colour;
  logic       hit_window;
  logic       miss;
  logic       overflow;
  logic       busy;

  always #5 clk = ~clk;

  note_scroller #(
    .NUM_NOTES(NumNotes),
    .FRAME_DIV(FrameDiv)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .spawn       (spawn),
    .spawn_colour(spawn_colour),
    .draw_done   (draw_done),
    .draw_req    (draw_req),
    .draw_x      (draw_x),
    .draw_colour (draw_colour),
    .hit_window  (hit_window),
    .miss        (miss),
    .overflow    (overflow),
    .busy        (busy)
  );

  // Model: a plain list of notes, indexed by slot.
  bit  mv[NumNotes];
  int  mx[NumNotes];
  int  mc[NumNotes];
  ev_t exp_q[$];
  ev_t obs_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic ev_t mk_ev(input int kind, input int x, input int c, input logic h);
    return {2'(kind), 8'(x), 3'(c), h};
  endfunction

  function automatic int free_slot();
    for (int i = 0; i < NumNotes; i++) if (!mv[i]) return i;
    return -1;
  endfunction

  function automatic logic model_hit();
    for (int i = 0; i < NumNotes; i++) if (mv[i] && mx[i] >= HitLo && mx[i] <= HitHi) return 1'b1;
    return 1'b0;
  endfunction

  // Every live note, lowest slot first: erase at old x, then either retire or draw one pixel left.
  function automatic void build_step();
    exp_q.delete();
    for (int i = 0; i < NumNotes; i++) begin
      if (mv[i]) begin
        exp_q.push_back(mk_ev(1, mx[i], Bg, 1'b0));
        mx[i] = mx[i] - 1;
        if (mx[i] == XEnd) begin
          mv[i] = 1'b0;
          exp_q.push_back(mk_ev(2, 0, 0, 1'b0));
        end else begin
          exp_q.push_back(mk_ev(1, mx[i], mc[i], model_hit()));
        end
      end
    end
  endfunction

  task automatic idle_spawn(input logic [2:0] c);
    int f;
    f = free_slot();
    spawn = 1'b1;
    spawn_colour = c;
    @(negedge clk);
    spawn = 1'b0;
    check("idle_spawn_overflow", overflow, (f < 0));
    if (f >= 0) begin
      mv[f] = 1'b1;
      mx[f] = XStart;
      mc[f] = c;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_draw_req"}, draw_req, 1'b0);
    check({tag, "_draw_x"}, draw_x, 8'd0);
    check({tag, "_draw_colour"}, draw_colour, Bg);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_miss"}, miss, 1'b0);
    check({tag, "_overflow"}, overflow, 1'b0);
    check({tag, "_hit_window"}, hit_window, 1'b0);
  endtask

  // One scroll step: enable the frame counter, act as the square drawer until the scan ends.
  task automatic service_step(input int dly_fixed, input bit hold_first, input int mid_spawns);
    int          n = 0;
    int          k = 0;
    int          dly = 0;
    int          pend_c = 0;
    int          f;
    bit          active = 1'b0;
    bit          first = 1'b1;
    bit          pend = 1'b0;
    bit          exp_drop = 1'b0;
    logic [11:0] cur = '0;
    build_step();
    obs_q.delete();
    enable = 1'b1;
    while (!busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("step_latency", n, FrameDiv);
    while (busy && k < 2000) begin
      draw_done = 1'b0;
      spawn = 1'b0;
      if (k == 1 && mid_spawns >= 1) begin
        pend_c = $urandom_range(1, 7);
        spawn = 1'b1;
        spawn_colour = 3'(pend_c);
        pend = 1'b1;
      end
      if (k == 2 && mid_spawns >= 1) begin
        check("mid_spawn_first_overflow", overflow, 1'b0);
        if (mid_spawns >= 2) begin
          spawn = 1'b1;
          spawn_colour = 3'($urandom_range(1, 7));
        end
      end
      if (k == 3 && mid_spawns >= 2) check("mid_spawn_second_overflow", overflow, 1'b1);
      if (miss) obs_q.push_back(mk_ev(2, 0, 0, 1'b0));
      if (active) begin
        check("req_hold_stable", {draw_req, draw_x, draw_colour}, cur);
        if (dly == 0) begin
          draw_done = 1'b1;
          active = 1'b0;
        end else begin
          dly--;
        end
      end else if (draw_req) begin
        cur = {draw_req, draw_x, draw_colour};
        obs_q.push_back(mk_ev(1, draw_x, draw_colour, (draw_colour != Bg) ? hit_window : 1'b0));
        active = 1'b1;
        if (hold_first && first) dly = 49;
        else if (dly_fixed >= 0) dly = dly_fixed;
        else dly = $urandom_range(0, 2);
        first = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    enable = 1'b0;
    spawn = 1'b0;
    draw_done = 1'b0;
    check("scan_ends", busy, 1'b0);
    check("event_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("event_%0d", i), obs_q[i], exp_q[i]);
    if (pend) begin
      f = free_slot();
      if (f < 0) begin
        exp_drop = 1'b1;
      end else begin
        mv[f] = 1'b1;
        mx[f] = XStart;
        mc[f] = pend_c;
      end
    end
    @(negedge clk);
    check("idle_entry_overflow", overflow, exp_drop);
    check("idle_hit_window", hit_window, model_hit());
    check("idle_busy", busy, 1'b0);
  endtask

  initial begin
    int n;
    int mid;
    reset = 1'b1;
    enable = 1'b0;
    spawn = 1'b0;
    spawn_colour = '0;
    draw_done = 1'b0;
    for (int i = 0; i < NumNotes; i++) mv[i] = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // Basic scroll: erase at 156 in background, draw at 155 in the note colour.
    idle_spawn(3'b100);
    service_step(1, 1'b0, 0);

    // Two spawns during a scan: first pends and lands at IDLE, second overflows.
    service_step(-1, 1'b0, 2);

    // Fill every slot, then one more spawn must overflow.
    while (free_slot() >= 0) idle_spawn(3'($urandom_range(1, 7)));
    idle_spawn(3'b011);

    // Drawer stalls 50 cycles on the first square.
    service_step(-1, 1'b1, 0);

    // Random run long enough for notes to cross the hit window and retire.
    for (int s = 0; s < 175; s++) begin
      if ($urandom_range(0, 3) == 0) idle_spawn(3'($urandom_range(1, 7)));
      mid = $urandom_range(0, 5);
      service_step(-1, 1'b0, (mid <= 2) ? mid : 0);
    end

    // Reset in the middle of an erase handshake; a late draw_done must be ignored.
    idle_spawn(3'b101);
    enable = 1'b1;
    n = 0;
    while (!draw_req && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("reset_test_req_seen", draw_req, 1'b1);
    enable = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("mid_reset");
    for (int i = 0; i < NumNotes; i++) mv[i] = 1'b0;
    draw_done = 1'b1;
    @(negedge clk);
    draw_done = 1'b0;
    check("late_done_draw_req", draw_req, 1'b0);
    check("late_done_busy", busy, 1'b0);
    service_step(-1, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
